// File: rtl/snes_load_pkg.sv
// Shared types and constants for the cartridge image loader.
//   load_state_t      : loader sequencing states
//   mem_word_t        : payload word plus byte enables sent to the SDRAM write port
//   HDR_BYTES_DEFAULT : size of the cartridge header routed to the header registers
//   SNES_HDR_STRIDE   : copier-header block size, the usual padding ahead of the image
package snes_load_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    SKIP    = 3'd2,
    PAYLOAD = 3'd3,
    FLUSH   = 3'd4,
    DONE    = 3'd5,
    FAIL    = 3'd6
  } load_state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  be;
  } mem_word_t;

  localparam int unsigned HDR_BYTES_DEFAULT = 64;
  localparam int unsigned SNES_HDR_STRIDE   = 512;

endpackage

// File: rtl/load_byte_fifo.sv
// Small byte FIFO decoupling the loader sources (which cannot be stalled)
// from the header/SDRAM sequencing.
// Ports:
//   wclk, resetn : clock, synchronous active-low reset
//   push_i       : write wdata_i this cycle
//   pop_i        : consume the head entry this cycle (ignored when empty)
//   wdata_i      : byte to push
//   rdata_c      : head entry (combinational read of the storage)
//   full_o       : registered, DEPTH entries held
//   empty_o      : registered, no entries held
//   overflow_c   : push while full with no simultaneous pop (byte is lost)
module load_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       wclk,
  input  logic       resetn,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_c,
  output logic       full_o,
  output logic       empty_o,
  output logic       overflow_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A pop frees the slot, so a push into a full FIFO is legal in the same cycle.
  always_comb begin
    do_pop     = pop_i & ~empty_q;
    do_push    = push_i & (~full_q | do_pop);
    overflow_c = push_i & full_q & ~do_pop;
    wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
    count_d    = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
  end

  // Pointer/occupancy state; flags are registered from the next count.
  always_ff @(posedge wclk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge wclk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/rom_load_ctrl.sv
// Cartridge image load sequencer. Arbitrates two byte-stream sources, routes the
// leading header bytes to the header registers, optionally discards padding, and
// packs the remaining payload into little-endian 16-bit SDRAM writes (req/ack).
// Optional build macro ROM_LOAD_CHECKSUM_EN: rom_sum carries a 16-bit wrapping
// sum of the payload bytes; otherwise rom_sum is tied to zero.
// Ports:
//   wclk, resetn                         : clock, synchronous active-low reset
//   srcN_data/valid/loading/fail         : source N byte stream and status (N = 0, 1)
//   hdr_we, hdr_addr, hdr_data           : header byte write
//   mem_req, mem_ack, mem_addr,
//   mem_wdata, mem_be                    : SDRAM ROM-region word write port
//   active_src, loading, done, fail      : load status
//   rom_bytes, rom_sum                   : payload byte count / checksum
module rom_load_ctrl
  import snes_load_pkg::*;
#(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned HDR_BYTES  = HDR_BYTES_DEFAULT,
  parameter int unsigned PAD_BYTES  = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              wclk,
  input  logic              resetn,
  input  logic [7:0]        src0_data,
  input  logic              src0_valid,
  input  logic              src0_loading,
  input  logic              src0_fail,
  input  logic [7:0]        src1_data,
  input  logic              src1_valid,
  input  logic              src1_loading,
  input  logic              src1_fail,
  output logic              hdr_we,
  output logic [5:0]        hdr_addr,
  output logic [7:0]        hdr_data,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  output logic              active_src,
  output logic              loading,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W:0]   rom_bytes,
  output logic [15:0]       rom_sum
);

  localparam int unsigned SEG_MAX = (HDR_BYTES > PAD_BYTES) ? HDR_BYTES : PAD_BYTES;
  localparam int unsigned CNT_W   = $clog2(SEG_MAX + 1);

  load_state_t       state_q, state_d;
  logic              active_src_q, active_src_d;
  logic              loading_q, loading_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              hdr_we_q, hdr_we_d;
  logic [5:0]        hdr_addr_q, hdr_addr_d;
  logic [7:0]        hdr_data_q, hdr_data_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  mem_word_t         word_q, word_d;
  logic [7:0]        low_q, low_d;
  logic              have_low_q, have_low_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   bytes_q, bytes_d;
`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  logic       grant_src_c, any_load_c, push_src_c, push_c;
  logic [7:0] push_data_c;
  logic       sel_loading_c, sel_fail_c;
  logic       stall_c, pop_c;
  logic [7:0] rdata_c;
  logic       full_c, empty_c, overflow_c;

  // Source selection: in IDLE the prospective grant feeds the FIFO so a byte
  // arriving with the rising loading edge is not lost; afterwards the lock holds.
  always_comb begin
    grant_src_c   = src0_loading ? 1'b0 : 1'b1;
    any_load_c    = src0_loading | src1_loading;
    push_src_c    = (state_q == IDLE) ? grant_src_c : active_src_q;
    push_data_c   = push_src_c ? src1_data : src0_data;
    push_c        = (push_src_c ? src1_valid : src0_valid) &
                    (((state_q == IDLE) & any_load_c) |
                     (state_q inside {HEADER, SKIP, PAYLOAD}));
    sel_loading_c = active_src_q ? src1_loading : src0_loading;
    sel_fail_c    = active_src_q ? src1_fail : src0_fail;
  end

  // Pop acceptance: every pop is held off while a write is outstanding.
  always_comb begin
    stall_c = mem_req_q & ~mem_ack;
    pop_c   = ~empty_c & ((state_q == HEADER) | (state_q == SKIP) |
                          ((state_q == PAYLOAD) & ~stall_c));
  end

  load_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .wclk       (wclk),
    .resetn     (resetn),
    .push_i     (push_c),
    .pop_i      (pop_c),
    .wdata_i    (push_data_c),
    .rdata_c    (rdata_c),
    .full_o     (full_c),
    .empty_o    (empty_c),
    .overflow_c (overflow_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    active_src_d = active_src_q;
    loading_d    = loading_q;
    done_d       = 1'b0;
    fail_d       = fail_q;
    hdr_we_d     = 1'b0;
    hdr_addr_d   = hdr_addr_q;
    hdr_data_d   = hdr_data_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    word_d       = word_q;
    low_d        = low_q;
    have_low_d   = have_low_q;
    cnt_d        = cnt_q;
    bytes_d      = bytes_q;
`ifdef ROM_LOAD_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    // Retire an acknowledged write; a new word may be issued in the same cycle.
    if (mem_req_q && mem_ack) begin
      mem_req_d  = 1'b0;
      mem_addr_d = mem_addr_q + ADDR_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (any_load_c) begin
          state_d      = HEADER;
          active_src_d = grant_src_c;
          loading_d    = 1'b1;
          cnt_d        = '0;
          bytes_d      = '0;
          mem_addr_d   = '0;
          have_low_d   = 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
          sum_d        = '0;
`endif
        end
      end

      HEADER: begin
        if (pop_c) begin
          hdr_we_d   = 1'b1;
          hdr_addr_d = 6'(cnt_q);
          hdr_data_d = rdata_c;
          if (cnt_q == CNT_W'(HDR_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = (PAD_BYTES > 0) ? SKIP : PAYLOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!sel_loading_c) begin
          state_d   = FAIL;
          fail_d    = 1'b1;
          loading_d = 1'b0;
        end
      end

      SKIP: begin
        if (pop_c) begin
          if (cnt_q == CNT_W'(PAD_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = PAYLOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!sel_loading_c) begin
          state_d   = FAIL;
          fail_d    = 1'b1;
          loading_d = 1'b0;
        end
      end

      PAYLOAD: begin
        if (pop_c) begin
          bytes_d = (&bytes_q) ? bytes_q : bytes_q + (ADDR_W + 1)'(1);
`ifdef ROM_LOAD_CHECKSUM_EN
          sum_d   = sum_q + 16'(rdata_c);
`endif
          if (!have_low_q) begin
            low_d      = rdata_c;
            have_low_d = 1'b1;
          end else begin
            word_d.data = {rdata_c, low_q};
            word_d.be   = 2'b11;
            mem_req_d   = 1'b1;
            have_low_d  = 1'b0;
          end
        end else if (!sel_loading_c && empty_c && !push_c && !stall_c) begin
          // Stream ended with no write outstanding: flush a lone byte or finish.
          if (have_low_q) begin
            word_d.data = {8'h00, low_q};
            word_d.be   = 2'b01;
            mem_req_d   = 1'b1;
            have_low_d  = 1'b0;
            state_d     = FLUSH;
          end else begin
            state_d   = DONE;
            done_d    = 1'b1;
            loading_d = 1'b0;
          end
        end
      end

      FLUSH: begin
        if (mem_req_q && mem_ack) begin
          state_d   = DONE;
          done_d    = 1'b1;
          loading_d = 1'b0;
        end
      end

      DONE: begin
        if (!sel_loading_c) begin
          state_d = IDLE;
        end
      end

      FAIL: begin
        mem_req_d = 1'b0;
        loading_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Source error or lost byte aborts the load from any transferring state.
    if ((state_q inside {HEADER, SKIP, PAYLOAD, FLUSH}) && (sel_fail_c || overflow_c)) begin
      state_d   = FAIL;
      fail_d    = 1'b1;
      loading_d = 1'b0;
      mem_req_d = 1'b0;
      hdr_we_d  = 1'b0;
      done_d    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge wclk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      active_src_q <= 1'b0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      hdr_we_q     <= 1'b0;
      hdr_addr_q   <= '0;
      hdr_data_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      word_q       <= '0;
      low_q        <= '0;
      have_low_q   <= 1'b0;
      cnt_q        <= '0;
      bytes_q      <= '0;
`ifdef ROM_LOAD_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      active_src_q <= active_src_d;
      loading_q    <= loading_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      hdr_we_q     <= hdr_we_d;
      hdr_addr_q   <= hdr_addr_d;
      hdr_data_q   <= hdr_data_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      word_q       <= word_d;
      low_q        <= low_d;
      have_low_q   <= have_low_d;
      cnt_q        <= cnt_d;
      bytes_q      <= bytes_d;
`ifdef ROM_LOAD_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign hdr_we     = hdr_we_q;
  assign hdr_addr   = hdr_addr_q;
  assign hdr_data   = hdr_data_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = word_q.data;
  assign mem_be     = word_q.be;
  assign active_src = active_src_q;
  assign loading    = loading_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign rom_bytes  = bytes_q;
`ifdef ROM_LOAD_CHECKSUM_EN
  assign rom_sum    = sum_q;
`else
  assign rom_sum    = 16'h0000;
`endif

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences cartridge image loading from up to two byte-stream sources into the header registers and the SDRAM ROM region. Sources are the SD/flash loader (src 0) and the simulation/test loader (src 1).
- Arbitrates between the sources and strips and forwards the 64-byte header.
- Packs payload bytes into 16-bit words and issues them to the memory-controller write port with a req/ack handshake.
- Buffers bytes in a small FIFO, because sources have no backpressure.

Parameters:
- ADDR_W, 22: word-address width of the ROM region (8 MB).
- HDR_BYTES, 64: leading stream bytes routed to the header port.
- PAD_BYTES, 0: bytes discarded after the header (448 for sources that do not skip padding themselves).
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of 2 and at least 2.

Ports:
- wclk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- src0_data  in  8  source 0 byte
- src0_valid  in  1  source 0 byte strobe
- src0_loading  in  1  source 0 has a transfer in progress
- src0_fail  in  1  source 0 error
- src1_data, src1_valid, src1_loading, src1_fail  in  8/1/1/1  same as source 0, for source 1
- hdr_we  out  1  header byte write strobe
- hdr_addr  out  6  header byte index
- hdr_data  out  8  header byte
- mem_req  out  1  write request; held high until ack
- mem_ack  in  1  one-cycle acknowledge from the memory controller
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  16  little-endian word: even byte in [7:0], odd byte in [15:8]
- mem_be  out  2  byte enables
- active_src  out  1  source currently granted
- loading  out  1  high from grant until DONE/FAIL
- done  out  1  one-cycle pulse when the load completes
- fail  out  1  sticky error
- rom_bytes  out  ADDR_W+1  payload byte count
- rom_sum  out  16  payload checksum (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0.
- Reset is synchronous and overrides everything, including a mid-load transfer: mem_req drops the same cycle, and any in-flight ack is ignored.
- Arbitration, IDLE state:
  - Grant the first source whose loading is high; src0 wins a simultaneous request.
  - Latch active_src. The grant is locked until DONE or FAIL; the ungranted source's valid strobes are ignored.
- States:
  - IDLE -> HEADER on grant.
  - HEADER: pops HDR_BYTES bytes. Each pop gives hdr_we=1 with hdr_addr = byte index, one cycle, registered.
    - Exits to SKIP if PAD_BYTES>0, else to PAYLOAD.
  - SKIP: pops and discards PAD_BYTES bytes -> PAYLOAD.
  - PAYLOAD:
    - An even-index byte is held in a low register. The odd byte completes the word: mem_wdata={odd,even}, mem_be=2'b11, mem_req=1.
    - The next pop is stalled while mem_req=1 and no mem_ack has arrived. mem_addr increments on ack and wraps at 2^ADDR_W.
    - The word address starts at 0.
  - PAYLOAD ends when the granted source's loading falls and the FIFO is empty. If a byte is pending (odd count) -> FLUSH, else -> DONE.
  - FLUSH: issues mem_wdata={8'h00,even}, mem_be=2'b01, then -> DONE on ack.
  - DONE: done=1 for one cycle; rom_bytes holds the final count. Returns to IDLE once the granted source's loading is low; a new grant starts a fresh load with counters cleared.
  - FAIL: sticky until reset; mem_req=0; loading=0.
- FIFO: registered, push on the granted source's valid, pop when the state machine accepts.
  - Simultaneous push and pop while full is allowed.
  - A push while full with no pop -> FAIL (overflow).
- Errors: granted srcN_fail=1 in any active state -> FAIL within 1 cycle.
- Early end: loading falls during HEADER or SKIP -> FAIL.
- rom_bytes counts payload bytes only and saturates at 2^(ADDR_W+1)-1.
- Latency: source byte -> hdr_we, at most 3 cycles; odd payload byte -> mem_req, at most 3 cycles.

Optional Feature:
- ROM_LOAD_CHECKSUM_EN defined: rom_sum is the 16-bit wrapping sum of all payload bytes, with padding excluded. It updates on each pop in PAYLOAD and is valid when done is pulsed.
- Undefined: rom_sum is tied to 16'h0000 and no adder is generated.

Decomposition:
- Package snes_load_pkg holds:
  - enum load_state_t {IDLE, HEADER, SKIP, PAYLOAD, FLUSH, DONE, FAIL};
  - localparam HDR_BYTES_DEFAULT=64 and SNES_HDR_STRIDE=512.
- One sub-module, load_byte_fifo: parameterised depth, with push/pop/full/empty/overflow outputs. It is instantiated once.

Test Plan:
- Single load: src1 sends 64 header bytes, then bytes 0x00..0x09 with ack 2 cycles after req.
  - Expect 64 hdr_we pulses with hdr_addr 0..63.
  - Expect 5 writes: addr 0 data 16'h0100, ..., addr 4 data 16'h0908, all mem_be 2'b11.
  - Expect done pulse, rom_bytes=10.
- Odd length: payload 0xAA,0xBB,0xCC -> write 16'hBBAA be 11, then 16'h00CC be 01; rom_bytes=3. With ROM_LOAD_CHECKSUM_EN, rom_sum=16'h0231.
- Arbitration: src0 and src1 raise loading in the same cycle -> active_src=0; src1 bytes are ignored and no write carries src1 data.
- Backpressure and overflow: hold mem_ack low while src0 streams a byte every cycle -> fail=1 once the FIFO holds 4 bytes and a 5th arrives; mem_req drops.
- Error and early end: src0_fail during PAYLOAD -> fail next cycle. Separately, loading falls after 30 header bytes -> fail.
- Reset mid-load: resetn low for 1 cycle with mem_req high -> all outputs 0 next cycle. A subsequent full load starts at mem_addr 0.
